// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and default constants for the pipeline stall controller.
//   state_t           : controller FSM states (RUN, MEM_WAIT, FLUSH)
//   DEF_FLUSH_CYCLES  : default number of cycles IF/ID is flushed after a branch
//   DEF_MEM_TIMEOUT   : default MEM_WAIT cycle count that raises the timeout flag
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam int unsigned DEF_FLUSH_CYCLES = 1;
    localparam int unsigned DEF_MEM_TIMEOUT  = 255;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Unsigned up-counter that saturates at MAX_VAL (default: all ones).
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous reset, active-high, clears value
//   inc    : count up by one (ignored once at_max)
//   clr    : restart the count; together with inc the counter restarts at 1,
//            so the current cycle is counted as the first one
//   value  : current count
//   at_max : value has reached MAX_VAL
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             at_max
);

    assign at_max = (value == MAX_VAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= inc ? WIDTH'(1) : '0;
        end else if (inc && !at_max) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
// Central sequencer for the 5-stage pipeline's freeze, bubble and flush
// controls. Combines the RAW hazard indication, the EXE-stage branch decision
// and the multicycle data-memory handshake. All control outputs are Mealy
// (same-cycle response); priority is memory wait > branch flush > hazard stall.
//
// Ports:
//   clk, rst         : clock (rising edge), asynchronous active-high reset
//   hazard_detected  : RAW hazard from the hazard detection unit
//   branch_taken     : taken branch/jump resolved in EXE
//   mem_req          : MEM stage has a load/store in flight
//   mem_ready        : data memory completes the access this cycle
//   freeze_pc        : hold PC
//   freeze_if_id     : hold IF/ID register
//   bubble_id_exe    : load NOP into ID/EXE
//   flush_if_id      : clear IF/ID register
//   freeze_all       : hold every pipeline register
//   mem_timeout_err  : sticky memory-timeout flag (cleared only by rst)
//   stall_cycles     : hazard-stall cycle count (optional)
//   flush_cycles     : flush cycle count (optional)
//
// Build option: define STALL_PERF_CNT_EN to build the two saturating
// performance counters; otherwise stall_cycles/flush_cycles read 0.
// -----------------------------------------------------------------------------
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int unsigned MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             bubble_id_exe,
    output logic             flush_if_id,
    output logic             freeze_all,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    localparam int unsigned WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned FLUSH_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FLUSH_W-1:0] FLUSH_RELOAD = FLUSH_W'(FLUSH_CYCLES - 1);

    state_t             state, state_nxt;
    logic [FLUSH_W-1:0] flush_cnt, flush_cnt_nxt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               wait_at_max;
    logic               wait_load, wait_inc;
    logic               err_q, err_set;
    logic               mem_stall;

    logic freeze_pc_c, freeze_if_id_c, bubble_c, flush_c, freeze_all_c;

    assign mem_stall = mem_req & ~mem_ready;

    always_comb begin
        state_nxt      = state;
        flush_cnt_nxt  = flush_cnt;
        wait_load      = 1'b0;
        wait_inc       = 1'b0;
        freeze_pc_c    = 1'b0;
        freeze_if_id_c = 1'b0;
        bubble_c       = 1'b0;
        flush_c        = 1'b0;
        freeze_all_c   = 1'b0;

        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    freeze_all_c   = 1'b1;
                    freeze_pc_c    = 1'b1;
                    freeze_if_id_c = 1'b1;
                    wait_load      = 1'b1;
                    state_nxt      = MEM_WAIT;
                end else if (branch_taken) begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    // A single-cycle flush is fully covered by this cycle.
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt     = FLUSH;
                        flush_cnt_nxt = FLUSH_RELOAD;
                    end
                end else if (hazard_detected) begin
                    freeze_pc_c    = 1'b1;
                    freeze_if_id_c = 1'b1;
                    bubble_c       = 1'b1;
                end
            end

            MEM_WAIT: begin
                // Frozen every cycle, including the completing one; branch and
                // hazard sources are frozen too and re-present in RUN.
                freeze_all_c   = 1'b1;
                freeze_pc_c    = 1'b1;
                freeze_if_id_c = 1'b1;
                if (mem_stall) begin
                    wait_inc = 1'b1;
                end else begin
                    // Completed (mem_ready) or aborted (mem_req dropped).
                    state_nxt = RUN;
                end
            end

            FLUSH: begin
                if (mem_stall) begin
                    // Flushed slots already hold bubbles; drop the remainder.
                    freeze_all_c   = 1'b1;
                    freeze_pc_c    = 1'b1;
                    freeze_if_id_c = 1'b1;
                    wait_load      = 1'b1;
                    flush_cnt_nxt  = '0;
                    state_nxt      = MEM_WAIT;
                end else begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (branch_taken) begin
                        flush_cnt_nxt = FLUSH_RELOAD;
                    end else if (flush_cnt <= FLUSH_W'(1)) begin
                        flush_cnt_nxt = '0;
                        state_nxt     = RUN;
                    end else begin
                        flush_cnt_nxt = flush_cnt - FLUSH_W'(1);
                    end
                end
            end

            default: begin
                state_nxt     = RUN;
                flush_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // wait_cnt restarts at 1 on entry to MEM_WAIT and saturates at MEM_TIMEOUT.
    sat_counter #(
        .WIDTH   (WAIT_W),
        .MAX_VAL (WAIT_W'(MEM_TIMEOUT))
    ) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (wait_load | (wait_inc & ~wait_at_max)),
        .clr    (wait_load),
        .value  (wait_cnt),
        .at_max (wait_at_max)
    );

    // Flag is set on the same edge that wait_cnt reaches MEM_TIMEOUT.
    always_comb begin
        if (wait_load) begin
            err_set = (MEM_TIMEOUT == 1);
        end else begin
            err_set = wait_inc && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    // Combinational outputs would otherwise follow the inputs during reset.
    assign freeze_pc       = freeze_pc_c    & ~rst;
    assign freeze_if_id    = freeze_if_id_c & ~rst;
    assign bubble_id_exe   = bubble_c       & ~rst;
    assign flush_if_id     = flush_c        & ~rst;
    assign freeze_all      = freeze_all_c   & ~rst;
    assign mem_timeout_err = err_q;

`ifdef STALL_PERF_CNT_EN
    logic stall_at_max, flush_at_max;

    // freeze_pc together with a bubble only occurs for a RUN hazard stall.
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (freeze_pc_c & bubble_c & ~stall_at_max),
        .clr    (1'b0),
        .value  (stall_cycles),
        .at_max (stall_at_max)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (flush_c & ~flush_at_max),
        .clr    (1'b0),
        .value  (flush_cycles),
        .at_max (flush_at_max)
    );
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_controller
// Scoreboard bench: the driver applies one input vector per cycle, a
// behavioural model predicts that cycle's outputs and queues them; a monitor
// on the falling edge pops and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_pipeline_stall_controller;

    localparam int unsigned FC = 2;
    localparam int unsigned MT = 3;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hazard_detected = 1'b0;
    logic          branch_taken = 1'b0;
    logic          mem_req = 1'b0;
    logic          mem_ready = 1'b0;
    logic          freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id;
    logic          freeze_all, mem_timeout_err;
    logic [CW-1:0] stall_cycles, flush_cycles;

    pipeline_stall_controller #(
        .FLUSH_CYCLES (FC),
        .MEM_TIMEOUT  (MT),
        .CNT_W        (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .freeze_pc       (freeze_pc),
        .freeze_if_id    (freeze_if_id),
        .bubble_id_exe   (bubble_id_exe),
        .flush_if_id     (flush_if_id),
        .freeze_all      (freeze_all),
        .mem_timeout_err (mem_timeout_err),
        .stall_cycles    (stall_cycles),
        .flush_cycles    (flush_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          fpc, fid, bub, fl, fall, err;
        int unsigned sc, fcn;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: "memory busy" flag, flush cycles still owed, cycles
    // spent waiting, sticky error and the two event totals.
    bit          m_busy = 0;
    int unsigned m_left = 0;
    int unsigned m_wait = 0;
    bit          m_err  = 0;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;

    task automatic cyc(input bit r, input bit hz, input bit br,
                       input bit mq, input bit mr, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; hazard_detected = hz; branch_taken = br;
        mem_req = mq; mem_ready = mr;
        e.fpc = 0; e.fid = 0; e.bub = 0; e.fl = 0; e.fall = 0; e.err = 0;
        e.sc = 0; e.fcn = 0; e.tag = tag;
        if (r) begin
            m_busy = 0; m_left = 0; m_wait = 0; m_err = 0;
            m_stall = 0; m_flush = 0;
        end else begin
`ifdef STALL_PERF_CNT_EN
            e.sc  = m_stall;
            e.fcn = m_flush;
`endif
            if (m_busy) begin
                e.fall = 1; e.fpc = 1; e.fid = 1;
                if (mq && !mr) begin
                    if (m_wait < MT) m_wait++;
                end else begin
                    m_busy = 0;
                end
            end else if (mq && !mr) begin
                e.fall = 1; e.fpc = 1; e.fid = 1;
                m_busy = 1; m_wait = 1; m_left = 0;
            end else if (br || m_left > 0) begin
                e.fl = 1; e.bub = 1;
                m_flush++;
                m_left = br ? FC - 1 : m_left - 1;
            end else if (hz) begin
                e.fpc = 1; e.fid = 1; e.bub = 1;
                m_stall++;
            end
            e.err = m_err;
            if (m_busy && m_wait >= MT) m_err = 1;
        end
        exp_q.push_back(e);
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            n_chk++;
            if (freeze_pc !== me.fpc || freeze_if_id !== me.fid ||
                bubble_id_exe !== me.bub || flush_if_id !== me.fl ||
                freeze_all !== me.fall || mem_timeout_err !== me.err ||
                stall_cycles !== CW'(me.sc) || flush_cycles !== CW'(me.fcn)) begin
                n_fail++;
                $display("FAIL %s @%0t: got pc=%0b ifid=%0b bub=%0b fl=%0b fall=%0b err=%0b sc=%0d fc=%0d, expected pc=%0b ifid=%0b bub=%0b fl=%0b fall=%0b err=%0b sc=%0d fc=%0d",
                         me.tag, $time, freeze_pc, freeze_if_id, bubble_id_exe,
                         flush_if_id, freeze_all, mem_timeout_err, stall_cycles,
                         flush_cycles, me.fpc, me.fid, me.bub, me.fl, me.fall,
                         me.err, me.sc, me.fcn);
            end
        end
    end

    initial begin
        // Reset state, with inputs active to show they are masked.
        cyc(1, 1, 1, 1, 0, "reset");
        cyc(1, 0, 0, 0, 0, "reset");
        cyc(0, 0, 0, 0, 0, "idle");

        // Two-cycle hazard stall.
        cyc(0, 1, 0, 0, 0, "hazard");
        cyc(0, 1, 0, 0, 0, "hazard");
        cyc(0, 0, 0, 0, 0, "hazard_end");

        // Branch with concurrent hazard: two flush cycles, no PC freeze.
        cyc(0, 1, 1, 0, 0, "branch");
        cyc(0, 1, 0, 0, 0, "branch_flush2");
        cyc(0, 0, 0, 0, 0, "branch_end");

        // Memory wait, ready on 4th cycle, pending branch flushes afterwards.
        cyc(0, 0, 1, 1, 0, "memwait");
        cyc(0, 1, 1, 1, 0, "memwait");
        cyc(0, 0, 1, 1, 0, "memwait");
        cyc(0, 0, 1, 1, 1, "memwait_ready");
        cyc(0, 0, 1, 0, 0, "mem_then_branch");
        cyc(0, 0, 0, 0, 0, "mem_then_flush2");
        cyc(0, 0, 0, 0, 0, "idle");

        // Ready arriving alongside the request: no stall at all.
        cyc(0, 0, 0, 1, 1, "mem_hit");

        // Memory stall overriding an ongoing flush.
        cyc(0, 0, 1, 0, 0, "flush_then_mem");
        cyc(0, 0, 0, 1, 0, "flush_then_mem");
        cyc(0, 0, 0, 1, 1, "flush_then_mem");
        cyc(0, 0, 0, 0, 0, "flush_then_mem");

        // Aborted access.
        cyc(0, 0, 0, 1, 0, "abort");
        cyc(0, 0, 0, 0, 0, "abort");
        cyc(0, 0, 0, 0, 0, "abort_idle");

        // Timeout: flag from 4th cycle, sticky past mem_ready.
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0, "timeout");
        cyc(0, 0, 0, 1, 1, "timeout_ready");
        cyc(0, 1, 0, 0, 0, "timeout_sticky");
        cyc(0, 0, 0, 0, 0, "timeout_sticky");

        // Reset mid-MEM_WAIT.
        cyc(0, 0, 0, 1, 0, "rst_midwait");
        cyc(0, 0, 0, 1, 0, "rst_midwait");
        cyc(1, 0, 0, 1, 0, "rst_midwait_rst");
        cyc(0, 0, 0, 0, 0, "rst_after");

        // Perf totals: 5 stall cycles and 3 flush cycles.
        cyc(1, 0, 0, 0, 0, "perf_rst");
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, "perf_stall");
        cyc(0, 0, 1, 0, 0, "perf_flush");
        cyc(0, 0, 1, 0, 0, "perf_flush");
        cyc(0, 0, 0, 0, 0, "perf_flush");
        cyc(0, 0, 0, 0, 0, "perf_total");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(99) < 2),
                ($urandom_range(99) < 30),
                ($urandom_range(99) < 15),
                ($urandom_range(99) < 30),
                ($urandom_range(99) < 45),
                "random");
        end
        cyc(0, 0, 0, 0, 0, "final");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central sequencer for the 5-stage MIPS pipeline's freeze, bubble and flush controls.
- Combines the hazard detection unit's `hazard_detected`, the EXE-stage branch decision and the multicycle data-memory handshake.
- Drives the PC, IF/ID and ID/EXE register enables and clears.
- Sits in the top-level datapath next to the hazard unit; it replaces ad-hoc stall glue.

Parameters:
- FLUSH_CYCLES, 1, cycles `flush_if_id` stays high after a taken branch; must be ≥1.
- MEM_TIMEOUT, 255, MEM_WAIT cycles after which `mem_timeout_err` is raised; must be ≥1.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous reset, active-high
- hazard_detected  input  1  RAW hazard from the hazard detection unit
- branch_taken  input  1  taken branch/jump resolved in EXE
- mem_req  input  1  MEM stage has a load/store in flight
- mem_ready  input  1  data memory completes the access this cycle
- freeze_pc  output  1  hold PC
- freeze_if_id  output  1  hold IF/ID register
- bubble_id_exe  output  1  load NOP (clear control bits) into ID/EXE
- flush_if_id  output  1  clear IF/ID register
- freeze_all  output  1  hold every pipeline register, including EX/MEM and MEM/WB
- mem_timeout_err  output  1  sticky memory-timeout flag
- stall_cycles  output  CNT_W  optional hazard-stall cycle count
- flush_cycles  output  CNT_W  optional flush cycle count

Behaviour:
- FSM states: RUN, MEM_WAIT, FLUSH. Reset value: RUN, with `flush_cnt`, `wait_cnt`, `mem_timeout_err` and the perf counters all 0.
- While rst=1, every output is forced to 0.
- Outputs are Mealy: they respond in the same cycle as their inputs, with zero latency.
- Priority in every state: memory wait > branch flush > hazard stall.
- RUN:
  - If mem_req & !mem_ready: freeze_all=1, freeze_pc=1, freeze_if_id=1; all other outputs 0; next state MEM_WAIT; `wait_cnt` <= 1.
  - Else if branch_taken: flush_if_id=1, bubble_id_exe=1, hazard ignored. Next state is FLUSH with `flush_cnt` <= FLUSH_CYCLES-1 if FLUSH_CYCLES>1; otherwise RUN.
  - Else if hazard_detected: freeze_pc=1, freeze_if_id=1, bubble_id_exe=1; stay RUN.
  - Else all outputs 0.
- MEM_WAIT:
  - freeze_all=freeze_pc=freeze_if_id=1 every cycle until mem_ready.
  - The cycle with mem_ready=1 is the final frozen cycle (freeze_all=1); next state RUN.
  - branch_taken and hazard_detected are ignored here. Their sources are frozen and still assert on return to RUN.
  - `wait_cnt` increments each cycle and saturates at MEM_TIMEOUT. When it equals MEM_TIMEOUT, `mem_timeout_err` <= 1; it stays set until rst. The FSM keeps waiting.
  - If mem_req drops without mem_ready (aborted access): return to RUN next cycle, with no error.
- FLUSH:
  - flush_if_id=1, bubble_id_exe=1; hazard_detected is ignored (squashed instructions).
  - `flush_cnt` decrements; at 1 the next state is RUN.
  - A new branch_taken reloads `flush_cnt` with FLUSH_CYCLES-1.
  - mem_req & !mem_ready overrides: go to MEM_WAIT, and the remaining flush count is discarded. The pipeline is frozen, so the flushed slots hold bubbles already.
- Reset mid-operation: state returns to RUN immediately (asynchronous); outputs are 0 during reset.
- Arithmetic: counters are unsigned. `wait_cnt` width is clog2(MEM_TIMEOUT+1); `flush_cnt` width is clog2(FLUSH_CYCLES+1). There is no wrap-around.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined:
  - `stall_cycles` increments on each cycle with hazard-stall outputs active in RUN.
  - `flush_cycles` increments on each cycle with flush_if_id=1.
  - Both saturate at all-ones and clear on rst.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package `pipe_ctrl_pkg`: state enum (RUN, MEM_WAIT, FLUSH) and the default FLUSH_CYCLES/MEM_TIMEOUT constants.
- One sub-module `sat_counter` (parameter WIDTH; ports inc, clr, value, at_max) is instantiated for `wait_cnt` and for both perf counters.

Test Plan:
- hazard_detected=1 for 2 cycles in RUN -> freeze_pc, freeze_if_id, bubble_id_exe high for exactly those 2 cycles; flush_if_id=0.
- branch_taken=1 for 1 cycle with FLUSH_CYCLES=2 and hazard_detected=1 -> flush_if_id high for 2 cycles; freeze_pc stays 0.
- mem_req=1, mem_ready asserted on the 4th cycle -> freeze_all high for 4 cycles; state RUN on the 5th; a pending branch_taken then flushes.
- MEM_TIMEOUT=3, mem_ready never arrives -> mem_timeout_err=1 from the 4th cycle onward; stays 1 after mem_ready; cleared only by rst.
- rst asserted mid-MEM_WAIT -> all outputs 0 in the same cycle; after release the FSM is in RUN with no freeze.
- STALL_PERF_CNT_EN defined, 5 hazard-stall cycles and 3 flush cycles -> stall_cycles=5, flush_cycles=3; macro undefined -> both read 0.
